// File: rtl/ot_read_pkg.sv
// Shared constants for the output-SRAM reader: FSM state encodings and loop-order selectors.
package ot_read_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic ORD_CHA_IN = 1'b0;
    localparam logic ORD_COL_IN = 1'b1;

endpackage

// File: rtl/count_yi_v4.sv
// Wrapping loop counter: clears on clr, steps on inc and returns to zero after reaching max.
module count_yi_v4 #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    input  logic [WIDTH-1:0] max,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= (cnt == max) ? '0 : cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ot_rbuf.sv
// Small synchronous return buffer; the head entry is presented combinationally and count is exact.
module ot_rbuf #(
    parameter int  WIDTH = 65,
    parameter int  DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ot_read_v2.sv
// Output-SRAM reader: walks a 3-level address loop and streams read data to the FIFO
// through a credit-limited return buffer, so back-pressure never drops or repeats a word.
module ot_read_v2
    import ot_read_pkg::*;
#(
    parameter int SRAM_DATA_BITS = 64,
    parameter int SRAM_ADDR_BITS = 10,
    parameter int SRAM_RD_LAT    = 1,
    parameter int OBUF_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    input  logic                      fifo_full_n,
    output logic                      fifo_write,
    output logic                      fifo_last,
    output logic [SRAM_DATA_BITS-1:0] fifo_data,
    input  logic [SRAM_DATA_BITS-1:0] data_from_sram,
    output logic [SRAM_ADDR_BITS-1:0] addr_otsr,
    output logic                      cen_otsr,
    output logic                      wen_otsr,
    input  logic [SRAM_ADDR_BITS-1:0] cfg_ot_base,
    input  logic [SRAM_ADDR_BITS-1:0] cfg_ot_tgpfnsub1,
    input  logic [SRAM_ADDR_BITS-1:0] cfg_ot_tchafnsub1,
    input  logic [SRAM_ADDR_BITS-1:0] cfg_ot_tcolfnsub1,
    input  logic [SRAM_ADDR_BITS-1:0] cfg_ot_sft_gp,
    input  logic [SRAM_ADDR_BITS-1:0] cfg_ot_sft_colpra,
    input  logic                      cfg_ot_order
);

    localparam int AB  = SRAM_ADDR_BITS;
    localparam int IFW = $clog2(SRAM_RD_LAT + 1) + 1;
    localparam int BCW = $clog2(OBUF_DEPTH + 1);

    logic [1:0]    state;
    logic [AB-1:0] cfg_base, cfg_tgp, cfg_tcha, cfg_tcol, cfg_sgp, cfg_scol;
    logic          cfg_order;
    logic [AB-1:0] g_cnt, c_cnt, k_cnt;
    logic [AB-1:0] gp_acc, ch_acc;
    logic          g_last, c_last, k_last;
    logic          inc_g, inc_c, inc_k;
    logic          accept, issue, final_issue;
    logic [SRAM_RD_LAT-1:0] vld, tag;
    logic [IFW-1:0]         in_flight;
    logic [BCW-1:0]         buf_count;
    logic [SRAM_DATA_BITS:0] head;

    assign accept = (state == S_IDLE) && start;

    // Credit check uses registered occupancy only, so fifo_full_n never reaches cen_otsr.
    assign issue  = (state == S_ISSUE) && ((int'(in_flight) + int'(buf_count)) < OBUF_DEPTH);

    assign g_last      = (g_cnt == cfg_tgp);
    assign c_last      = (c_cnt == cfg_tcha);
    assign k_last      = (k_cnt == cfg_tcol);
    assign inc_c       = issue && ((cfg_order == ORD_CHA_IN) || k_last);
    assign inc_k       = issue && ((cfg_order == ORD_COL_IN) || c_last);
    assign inc_g       = issue && c_last && k_last;
    assign final_issue = inc_g && g_last;

    count_yi_v4 #(.WIDTH(AB)) u_cnt_g (
        .clk(clk), .reset(reset), .clr(accept), .inc(inc_g), .max(cfg_tgp), .cnt(g_cnt)
    );
    count_yi_v4 #(.WIDTH(AB)) u_cnt_c (
        .clk(clk), .reset(reset), .clr(accept), .inc(inc_c), .max(cfg_tcha), .cnt(c_cnt)
    );
    count_yi_v4 #(.WIDTH(AB)) u_cnt_k (
        .clk(clk), .reset(reset), .clr(accept), .inc(inc_k), .max(cfg_tcol), .cnt(k_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cfg_base  <= '0;
            cfg_tgp   <= '0;
            cfg_tcha  <= '0;
            cfg_tcol  <= '0;
            cfg_sgp   <= '0;
            cfg_scol  <= '0;
            cfg_order <= 1'b0;
            gp_acc    <= '0;
            ch_acc    <= '0;
        end else begin
            case (state)
                S_IDLE:  if (start) state <= S_ISSUE;
                S_ISSUE: if (final_issue) state <= S_DRAIN;
                S_DRAIN: if (fifo_last && in_flight == '0) state <= S_DONE;
                default: state <= S_IDLE;
            endcase
            if (accept) begin
                cfg_base  <= cfg_ot_base;
                cfg_tgp   <= cfg_ot_tgpfnsub1;
                cfg_tcha  <= cfg_ot_tchafnsub1;
                cfg_tcol  <= cfg_ot_tcolfnsub1;
                cfg_sgp   <= cfg_ot_sft_gp;
                cfg_scol  <= cfg_ot_sft_colpra;
                cfg_order <= cfg_ot_order;
                gp_acc    <= cfg_ot_base;
                ch_acc    <= '0;
            end else begin
                if (inc_g) gp_acc <= g_last ? cfg_base : gp_acc + cfg_sgp;
                if (inc_c) ch_acc <= c_last ? '0 : ch_acc + cfg_scol;
            end
        end
    end

    // Each issue carries a valid bit and last-tag down a chain matching the SRAM latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
            tag <= '0;
        end else begin
            vld[0] <= issue;
            tag[0] <= final_issue;
            for (int i = 1; i < SRAM_RD_LAT; i++) begin
                vld[i] <= vld[i-1];
                tag[i] <= tag[i-1];
            end
        end
    end

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < SRAM_RD_LAT; i++) begin
            in_flight = in_flight + IFW'(vld[i]);
        end
    end

    ot_rbuf #(.WIDTH(SRAM_DATA_BITS + 1), .DEPTH(OBUF_DEPTH)) u_rbuf (
        .clk       (clk),
        .reset     (reset),
        .push      (vld[SRAM_RD_LAT-1]),
        .push_data ({tag[SRAM_RD_LAT-1], data_from_sram}),
        .pop       (fifo_write),
        .head      (head),
        .count     (buf_count)
    );

    assign fifo_write = (buf_count != '0) && fifo_full_n;
    assign fifo_data  = head[SRAM_DATA_BITS-1:0];
    assign fifo_last  = head[SRAM_DATA_BITS] && fifo_write;
    assign addr_otsr  = gp_acc + ch_acc + k_cnt;
    assign cen_otsr   = ~issue;
    assign wen_otsr   = 1'b1;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

endmodule

// File: tb/tb_ot_read_v2.sv
// Self-checking bench for ot_read_v2: random SRAM contents, a latency-accurate SRAM model,
// and a nested-loop address reference compared word by word against the FIFO stream.
module tb_ot_read_v2;

    localparam int DB    = 64;
    localparam int AB    = 10;
    localparam int LAT   = 3;
    localparam int DEPTH = 5;

    logic          clk;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic          fifo_full_n;
    logic          fifo_write;
    logic          fifo_last;
    logic [DB-1:0] fifo_data;
    logic [DB-1:0] data_from_sram;
    logic [AB-1:0] addr_otsr;
    logic          cen_otsr;
    logic          wen_otsr;
    logic [AB-1:0] cfg_ot_base, cfg_ot_tgpfnsub1, cfg_ot_tchafnsub1, cfg_ot_tcolfnsub1;
    logic [AB-1:0] cfg_ot_sft_gp, cfg_ot_sft_colpra;
    logic          cfg_ot_order;

    int vectors;
    int miscompares;

    logic [DB-1:0]  mem [1024];
    logic [AB-1:0]  sp_addr [LAT];
    logic [LAT-1:0] sp_vld;
    logic [DB-1:0]  junk;
    logic [AB-1:0]  exp_q [$];

    ot_read_v2 #(
        .SRAM_DATA_BITS(DB), .SRAM_ADDR_BITS(AB), .SRAM_RD_LAT(LAT), .OBUF_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .fifo_full_n(fifo_full_n), .fifo_write(fifo_write), .fifo_last(fifo_last),
        .fifo_data(fifo_data), .data_from_sram(data_from_sram), .addr_otsr(addr_otsr),
        .cen_otsr(cen_otsr), .wen_otsr(wen_otsr), .cfg_ot_base(cfg_ot_base),
        .cfg_ot_tgpfnsub1(cfg_ot_tgpfnsub1), .cfg_ot_tchafnsub1(cfg_ot_tchafnsub1),
        .cfg_ot_tcolfnsub1(cfg_ot_tcolfnsub1), .cfg_ot_sft_gp(cfg_ot_sft_gp),
        .cfg_ot_sft_colpra(cfg_ot_sft_colpra), .cfg_ot_order(cfg_ot_order)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM: data for a cen-low cycle appears exactly LAT cycles later; junk otherwise.
    always @(posedge clk) begin
        sp_vld[0]  <= ~cen_otsr;
        sp_addr[0] <= addr_otsr;
        for (int i = 1; i < LAT; i++) begin
            sp_vld[i]  <= sp_vld[i-1];
            sp_addr[i] <= sp_addr[i-1];
        end
        junk <= {$urandom, $urandom};
    end
    assign data_from_sram = sp_vld[LAT-1] ? mem[sp_addr[LAT-1]] : junk;

    task automatic checkOutput(input string tag, input logic [DB-1:0] got, input logic [DB-1:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Builds the expected address list from the loop rules, then runs one start..done sequence.
    task automatic applyStimulus(
        input logic [AB-1:0] base, tgp, tcha, tcol, sgp, scol,
        input logic ord, input int stall_pct, input int abort_at, input bit disturb
    );
        int n, limit, issued, written, first_wr, last_wr, done_cyc;
        bit finished, aborted;
        exp_q.delete();
        for (int g = 0; g <= int'(tgp); g++) begin
            if (ord == 1'b0) begin
                for (int k = 0; k <= int'(tcol); k++)
                    for (int c = 0; c <= int'(tcha); c++)
                        exp_q.push_back(AB'(int'(base) + g*int'(sgp) + c*int'(scol) + k));
            end else begin
                for (int c = 0; c <= int'(tcha); c++)
                    for (int k = 0; k <= int'(tcol); k++)
                        exp_q.push_back(AB'(int'(base) + g*int'(sgp) + c*int'(scol) + k));
            end
        end
        n = exp_q.size();
        limit = n * 20 + 60;
        @(posedge clk); #1;
        cfg_ot_base = base; cfg_ot_tgpfnsub1 = tgp; cfg_ot_tchafnsub1 = tcha;
        cfg_ot_tcolfnsub1 = tcol; cfg_ot_sft_gp = sgp; cfg_ot_sft_colpra = scol;
        cfg_ot_order = ord; start = 1'b1; fifo_full_n = 1'b1;
        @(negedge clk);
        checkOutput("busy_at_start", busy, 0);
        issued = 0; written = 0; first_wr = -1; last_wr = -1; done_cyc = -1;
        finished = 0; aborted = 0;
        for (int cyc = 1; cyc <= limit; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (disturb && (cyc == 3 || cyc == 8)) begin
                start = 1'b1;
                cfg_ot_base = AB'($urandom); cfg_ot_tgpfnsub1 = AB'($urandom);
                cfg_ot_tchafnsub1 = AB'($urandom); cfg_ot_tcolfnsub1 = AB'($urandom);
                cfg_ot_sft_gp = AB'($urandom); cfg_ot_sft_colpra = AB'($urandom);
                cfg_ot_order = ~ord;
            end
            fifo_full_n = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
            @(negedge clk);
            if (!cen_otsr) begin
                if (issued == 0) checkOutput("first_issue_cycle", cyc, 1);
                checkOutput("credit_limit", ((issued - written) < DEPTH), 1);
                if (issued < n) checkOutput("addr", addr_otsr, exp_q[issued]);
                else checkOutput("extra_issue", issued, n);
                issued++;
            end
            if (fifo_write) begin
                if (written == 0) first_wr = cyc;
                if (written < n) begin
                    checkOutput("data", fifo_data, mem[exp_q[written]]);
                    checkOutput("last_flag", fifo_last, (written == n - 1));
                end else begin
                    checkOutput("extra_write", written, n);
                end
                written++;
                last_wr = cyc;
            end else begin
                checkOutput("last_without_write", fifo_last, 0);
            end
            if (!fifo_full_n) checkOutput("write_while_full", fifo_write, 0);
            checkOutput("busy_during_run", busy, 1);
            if (done) begin
                done_cyc = cyc;
                finished = 1;
                break;
            end
            if (abort_at > 0 && written == abort_at) begin
                aborted = 1;
                break;
            end
        end
        if (aborted) begin
            reset = 1'b1;
            @(posedge clk); #1;
            @(negedge clk);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_write", fifo_write, 0);
            checkOutput("rst_cen", cen_otsr, 1);
            checkOutput("rst_done", done, 0);
            @(posedge clk); #1;
            reset = 1'b0;
            for (int i = 0; i < LAT + 4; i++) begin
                @(negedge clk);
                checkOutput("no_done_after_reset", done, 0);
                checkOutput("idle_after_reset", busy, 0);
                @(posedge clk); #1;
            end
            return;
        end
        if (!finished) checkOutput("timeout_waiting_done", 0, 1);
        checkOutput("issue_count", issued, n);
        checkOutput("write_count", written, n);
        checkOutput("done_after_last", done_cyc, last_wr + 1);
        if (stall_pct == 0) begin
            checkOutput("first_write_cycle", first_wr, 2 + LAT);
            checkOutput("done_cycle", done_cyc, n + 2 + LAT);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("idle_after_done", busy, 0);
        checkOutput("done_pulse_width", done, 0);
    endtask

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
        reset = 1'b1; start = 1'b0; fifo_full_n = 1'b1;
        cfg_ot_base = '0; cfg_ot_tgpfnsub1 = '0; cfg_ot_tchafnsub1 = '0;
        cfg_ot_tcolfnsub1 = '0; cfg_ot_sft_gp = '0; cfg_ot_sft_colpra = '0;
        cfg_ot_order = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_write", fifo_write, 0);
        checkOutput("reset_last", fifo_last, 0);
        checkOutput("reset_cen", cen_otsr, 1);
        checkOutput("reset_wen", wen_otsr, 1);
        checkOutput("reset_addr", addr_otsr, 0);
        checkOutput("reset_data", fifo_data, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        $display("[TB] order 0, base 0, 128 words");
        applyStimulus(10'd0, 10'd1, 10'd7, 10'd7, 10'd64, 10'd8, 1'b0, 0, 0, 1'b0);
        $display("[TB] order 1, base 100, 128 words");
        applyStimulus(10'd100, 10'd1, 10'd7, 10'd7, 10'd64, 10'd8, 1'b1, 0, 0, 1'b0);
        $display("[TB] 50 percent back-pressure");
        applyStimulus(10'd0, 10'd1, 10'd7, 10'd7, 10'd64, 10'd8, 1'b0, 50, 0, 1'b0);
        applyStimulus(10'd1000, 10'd1, 10'd7, 10'd7, 10'd64, 10'd8, 1'b1, 50, 0, 1'b0);
        $display("[TB] all-zero configuration");
        applyStimulus(10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 1'b0, 0, 0, 1'b0);
        applyStimulus(10'd517, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 1'b1, 0, 0, 1'b0);
        $display("[TB] reset at word 20, then full rerun");
        applyStimulus(10'd0, 10'd1, 10'd7, 10'd7, 10'd64, 10'd8, 1'b0, 0, 20, 1'b0);
        applyStimulus(10'd0, 10'd1, 10'd7, 10'd7, 10'd64, 10'd8, 1'b0, 0, 0, 1'b0);
        $display("[TB] start and cfg changes while busy");
        applyStimulus(10'd33, 10'd2, 10'd3, 10'd4, 10'd200, 10'd17, 1'b1, 0, 0, 1'b1);
        applyStimulus(10'd900, 10'd1, 10'd2, 10'd5, 10'd300, 10'd90, 1'b0, 30, 0, 1'b1);
        $display("[TB] random configurations");
        for (int r = 0; r < 6; r++) begin
            applyStimulus(AB'($urandom), AB'($urandom_range(2)), AB'($urandom_range(3)),
                          AB'($urandom_range(3)), AB'($urandom), AB'($urandom),
                          1'($urandom_range(1)), $urandom_range(70), 0, 1'($urandom_range(1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ot_read_v2.md
Name: ot_read_v2

Overview:
Next-generation output-SRAM reader. It walks a 3-level loop (column group / output-channel group / column-in-parallel) and reads one word per address, with a configurable base address and a selectable loop order. Read data is streamed to the output FIFO through a small credit-controlled return buffer. Back-pressure from fifo_full_n never drops or duplicates a word, whatever the SRAM read latency. The block sits between the output SRAM and the output/DMA FIFO.

Parameters:
SRAM_DATA_BITS, 64, SRAM word and FIFO data width
SRAM_ADDR_BITS, 10, SRAM address width; also the width of all cfg fields and loop counters
SRAM_RD_LAT, 1, cycles from a cen_otsr-low cycle to valid data_from_sram (1 to 4)
OBUF_DEPTH, 4, return-buffer entries; must be at least SRAM_RD_LAT+2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; accepted only in IDLE
busy  out  1  high from the cycle after an accepted start through the done cycle
done  out  1  one-cycle pulse when the last word has been written to the FIFO
fifo_full_n  in  1  FIFO can accept a word this cycle
fifo_write  out  1  word is transferred this cycle
fifo_last  out  1  qualifies the final word of the run
fifo_data  out  SRAM_DATA_BITS  return-buffer head
data_from_sram  in  SRAM_DATA_BITS  SRAM read data
addr_otsr  out  SRAM_ADDR_BITS  read address
cen_otsr  out  1  active-low chip enable
wen_otsr  out  1  tied to 1 (read only)
cfg_ot_base  in  SRAM_ADDR_BITS  start address
cfg_ot_tgpfnsub1  in  SRAM_ADDR_BITS  group count minus 1
cfg_ot_tchafnsub1  in  SRAM_ADDR_BITS  channel-group count minus 1
cfg_ot_tcolfnsub1  in  SRAM_ADDR_BITS  column count minus 1
cfg_ot_sft_gp  in  SRAM_ADDR_BITS  address stride per group
cfg_ot_sft_colpra  in  SRAM_ADDR_BITS  address stride per channel group
cfg_ot_order  in  1  0: channel innermost, then column, then group; 1: column innermost, then channel, then group

Behaviour:
- Reset values: busy=0, done=0, fifo_write=0, fifo_last=0, cen_otsr=1, wen_otsr=1, addr_otsr=0, fifo_data=0. Counters, accumulators and in-flight count are cleared; the return buffer is emptied.
- All cfg inputs are captured on an accepted start. Changes to cfg while busy have no effect. start while busy is ignored.
- FSM states:
  - IDLE -> ISSUE on start.
  - ISSUE -> DRAIN in the cycle after the final address is issued.
  - DRAIN -> DONE when the buffer is empty, the in-flight count is 0, and the last word has been written.
  - DONE -> IDLE unconditionally.
- busy = (state != IDLE). done = (state == DONE).
- Address = base + g*sft_gp + c*sft_colpra + k, modulo 2^SRAM_ADDR_BITS.
  - No multipliers. Use two registered accumulators: group-base (+sft_gp) and channel-offset (+sft_colpra).
  - Each accumulator reloads when its loop wraps. k is added last, combinationally.
- Issue rule: cen_otsr=0 in ISSUE only when in_flight + buf_count < OBUF_DEPTH. A pop in the same cycle is not credited.
  - The loop counters advance only on issue, so addr_otsr is held stable while stalled.
- Return path: data_from_sram is pushed into the buffer exactly SRAM_RD_LAT cycles after each issue, tracked by a valid shift chain. A last-tag travels with each entry.
- Output: fifo_write = buffer non-empty AND fifo_full_n. fifo_data = buffer head. fifo_last = head tag AND fifo_write. No combinational path from fifo_full_n to cen_otsr.
- Latency: with start accepted at cycle 0, the first issue is at cycle 1 and the first fifo_write is at cycle 2+SRAM_RD_LAT, if fifo_full_n=1.
- Throughput: one word per cycle sustained when fifo_full_n is held high.
- Word count: N = (tgp+1)(tcha+1)(tcol+1). All-zero cfg gives N=1; fifo_last is set on that single word.
- Stalls: fifo_full_n low for any duration loses no word and reorders nothing. Issue stops at most OBUF_DEPTH words ahead of the FIFO.
- Reset mid-run: the block returns to IDLE the next cycle, in-flight returns are discarded, and no done pulse is produced.

Decomposition:
- Package ot_read_pkg: FSM state localparams (IDLE, ISSUE, DRAIN, DONE) and order constants (ORD_CHA_IN=0, ORD_COL_IN=1).
- Sub-module ot_rbuf: synchronous FIFO, parametrised width (data+1 for the last-tag) and depth; provides count, push, pop.
- Loop counters reuse count_yi_v4.

Test Plan:
- Base 0, tgp=1, tcha=7, tcol=7, sft_gp=64, sft_colpra=8, order 0, fifo_full_n=1 -> 128 contiguous fifo_write. Addresses in order 0,8,...,56,1,9,...,127. fifo_last only on word 128. done 1 cycle after it.
- Same cfg with order 1, base 100 -> addresses 100..163 then 164..227. Word count 128.
- fifo_full_n toggled pseudo-randomly at 50%, SRAM_RD_LAT=3, OBUF_DEPTH=5 -> FIFO receives exactly the SRAM model's sequence with no loss or duplicate. cen_otsr is never low when in_flight+count=5.
- All cfg zero -> one read at base, one fifo_write with fifo_last=1. done at cycle 4 with SRAM_RD_LAT=1.
- reset asserted at word 20 of 128 -> next cycle busy=0, fifo_write=0, cen_otsr=1, no done. A following start runs the full 128 words correctly.
- start pulsed again while busy, and cfg changed mid-run -> ignored. The run completes with the originally captured cfg.
